// File: rtl/svm_smo_pair_ctrl_if.sv
// Bus bundle between the SMO pair controller and its surroundings: memory
// load/readback, training start, update-unit handshake and run status.
interface svm_smo_pair_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int IDX_W  = 4
);
   logic              load_en;
   logic [IDX_W-1:0]  load_idx;
   logic [DATA_W-1:0] load_alpha;
   logic              load_label;
   logic              start;
   logic              cal_finish;
   logic [DATA_W-1:0] new_a1;
   logic [DATA_W-1:0] new_a2;
   logic [DATA_W-1:0] new_b;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_alpha;
   logic [DATA_W-1:0] a1;
   logic [DATA_W-1:0] a2;
   logic [DATA_W-1:0] a_b;
   logic [IDX_W-1:0]  idx1;
   logic [IDX_W-1:0]  idx2;
   logic              label1;
   logic              label2;
   logic              cal_start;
   logic              busy;
   logic [IDX_W+3:0]  pass_cnt;
   logic              finish;
   logic              converged;
   logic              timeout;

   // Host / update-unit side
   modport master (
      output load_en, load_idx, load_alpha, load_label, start,
             cal_finish, new_a1, new_a2, new_b, rd_idx,
      input  rd_alpha, a1, a2, a_b, idx1, idx2, label1, label2,
             cal_start, busy, pass_cnt, finish, converged, timeout
   );

   // Controller side
   modport slave (
      input  load_en, load_idx, load_alpha, load_label, start,
             cal_finish, new_a1, new_a2, new_b, rd_idx,
      output rd_alpha, a1, a2, a_b, idx1, idx2, label1, label2,
             cal_start, busy, pass_cnt, finish, converged, timeout
   );
endinterface

// File: rtl/svm_smo_pair_ctrl.sv
// SMO pair-iteration controller: holds alphas, labels and bias, walks the
// pairs (i, i+1 mod N), hands each to the external update unit and writes the
// results back. Passes repeat until one changes nothing or the pass limit hits.
module svm_smo_pair_ctrl #(
   parameter int DATA_W      = 64,
   parameter int N_SAMPLES   = 16,
   parameter int IDX_W       = 4,
   parameter int MAX_PASSES  = 8,
   parameter int CAL_TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst_,
   svm_smo_pair_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE
   } state_t;

   localparam int                CNT_W      = $clog2(CAL_TIMEOUT) + 1;
   localparam int                PC_W       = IDX_W + 4;
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_SAMPLES - 1);
   // Counter value on the last WAIT cycle that may still see cal_finish.
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CAL_TIMEOUT - 2);
   localparam logic [PC_W-1:0]   PASS_LIMIT = PC_W'(MAX_PASSES);

   state_t state_reg, state_next;

   logic [DATA_W-1:0]  alpha_reg [N_SAMPLES];
   logic [N_SAMPLES-1:0] label_reg;
   logic [IDX_W-1:0]   i_reg, idx1_reg, idx2_reg;
   logic [DATA_W-1:0]  a1_reg, a2_reg, ab_reg, rd_alpha_reg;
   logic [DATA_W-1:0]  new_a1_reg, new_a2_reg, new_b_reg;
   logic               label1_reg, label2_reg, converged_reg, timeout_reg;
   logic [PC_W-1:0]    pass_cnt_reg;
   logic [IDX_W:0]     change_cnt_reg;
   logic [CNT_W-1:0]   wait_cnt_reg;

   logic [IDX_W-1:0]   i_succ;
   logic [PC_W-1:0]    pass_cnt_inc;
   logic               pair_changed;

   assign i_succ       = (i_reg == LAST_IDX) ? '0 : i_reg + 1'b1;
   assign pass_cnt_inc = (&pass_cnt_reg) ? pass_cnt_reg : pass_cnt_reg + 1'b1;
   // Raw bit comparison: the update unit's arithmetic format is opaque here.
   assign pair_changed = (new_a1_reg != a1_reg) || (new_a2_reg != a2_reg);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state decode
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (bus.start) state_next = S_SELECT;
         S_SELECT: state_next = S_ISSUE;
         S_ISSUE:  state_next = S_WAIT;
         S_WAIT: begin
            if (bus.cal_finish)              state_next = S_WRITE;
            else if (wait_cnt_reg == CNT_LAST) state_next = S_DONE;
         end
         S_WRITE:  state_next = S_NEXT;
         S_NEXT: begin
            if (i_reg != LAST_IDX)               state_next = S_SELECT;
            else if (change_cnt_reg == '0)       state_next = S_DONE;
            else if (pass_cnt_inc == PASS_LIMIT) state_next = S_DONE;
            else                                 state_next = S_SELECT;
         end
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Sample memory, pair registers and run bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_) begin
         for (int k = 0; k < N_SAMPLES; k++) alpha_reg[k] <= '0;
         label_reg      <= '0;
         i_reg          <= '0;
         idx1_reg       <= '0;
         idx2_reg       <= '0;
         a1_reg         <= '0;
         a2_reg         <= '0;
         ab_reg         <= '0;
         new_a1_reg     <= '0;
         new_a2_reg     <= '0;
         new_b_reg      <= '0;
         label1_reg     <= 1'b0;
         label2_reg     <= 1'b0;
         converged_reg  <= 1'b0;
         timeout_reg    <= 1'b0;
         pass_cnt_reg   <= '0;
         change_cnt_reg <= '0;
         wait_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               // Load lands at this edge, so a same-cycle start sees it in SELECT.
               if (bus.load_en && (bus.load_idx <= LAST_IDX)) begin
                  alpha_reg[bus.load_idx] <= bus.load_alpha;
                  label_reg[bus.load_idx] <= bus.load_label;
               end
               if (bus.start) begin
                  i_reg          <= '0;
                  pass_cnt_reg   <= '0;
                  change_cnt_reg <= '0;
                  converged_reg  <= 1'b0;
                  timeout_reg    <= 1'b0;
               end
            end
            S_SELECT: begin
               idx1_reg   <= i_reg;
               idx2_reg   <= i_succ;
               a1_reg     <= alpha_reg[i_reg];
               a2_reg     <= alpha_reg[i_succ];
               label1_reg <= label_reg[i_reg];
               label2_reg <= label_reg[i_succ];
            end
            S_ISSUE: wait_cnt_reg <= '0;
            S_WAIT: begin
               if (bus.cal_finish) begin
                  new_a1_reg <= bus.new_a1;
                  new_a2_reg <= bus.new_a2;
                  new_b_reg  <= bus.new_b;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
                  if (wait_cnt_reg == CNT_LAST) timeout_reg <= 1'b1;
               end
            end
            S_WRITE: begin
               // idx1 != idx2 always (N >= 2), so both writes are independent.
               alpha_reg[idx1_reg] <= new_a1_reg;
               alpha_reg[idx2_reg] <= new_a2_reg;
               ab_reg              <= new_b_reg;
               if (pair_changed) change_cnt_reg <= change_cnt_reg + 1'b1;
            end
            S_NEXT: begin
               if (i_reg != LAST_IDX) begin
                  i_reg <= i_reg + 1'b1;
               end else begin
                  pass_cnt_reg <= pass_cnt_inc;
                  if (change_cnt_reg == '0) begin
                     converged_reg <= 1'b1;
                  end else if (pass_cnt_inc != PASS_LIMIT) begin
                     i_reg          <= '0;
                     change_cnt_reg <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Readback port: registered, returns pre-write data on a same-cycle write
   always_ff @(posedge clk) begin
      if (!rst_)                       rd_alpha_reg <= '0;
      else if (bus.rd_idx <= LAST_IDX) rd_alpha_reg <= alpha_reg[bus.rd_idx];
      else                             rd_alpha_reg <= '0;
   end

   assign bus.rd_alpha  = rd_alpha_reg;
   assign bus.a1        = a1_reg;
   assign bus.a2        = a2_reg;
   assign bus.a_b       = ab_reg;
   assign bus.idx1      = idx1_reg;
   assign bus.idx2      = idx2_reg;
   assign bus.label1    = label1_reg;
   assign bus.label2    = label2_reg;
   assign bus.pass_cnt  = pass_cnt_reg;
   assign bus.converged = converged_reg;
   assign bus.timeout   = timeout_reg;
   assign bus.cal_start = (state_reg == S_ISSUE);
   assign bus.busy      = (state_reg != S_IDLE);
   assign bus.finish    = (state_reg == S_DONE);
endmodule

// File: tb/tb_svm_smo_pair_ctrl.sv
// Bench for svm_smo_pair_ctrl: table of whole training runs checked against a
// reference model, plus sequences for busy-time pulses, load+start and reset.
module tb_svm_smo_pair_ctrl;
   localparam int DW = 16, IW = 2, NS = 4, MAXP = 3, CTO = 8;
   localparam int M_ECHO = 0, M_INC = 1, M_SILENT = 2, M_HOLD = 3;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   always #5 clk = ~clk;

   svm_smo_pair_ctrl_if #(.DATA_W(DW), .IDX_W(IW)) bus();

   svm_smo_pair_ctrl #(
      .DATA_W(DW), .N_SAMPLES(NS), .IDX_W(IW),
      .MAX_PASSES(MAXP), .CAL_TIMEOUT(CTO)
   ) dut (
      .clk(clk), .rst_(rst_), .bus(bus)
   );

   typedef struct {
      logic [IW-1:0] i1, i2;
      logic [DW-1:0] a1, a2;
      logic          l1, l2;
   } pair_t;

   typedef struct {
      int            mode;
      logic [DW-1:0] a0, a1, a2, a3;
      logic [3:0]    lab;
      int            conv;
      int            pass;
      int            to;
      logic [DW-1:0] alpha0;
   } vec_t;

   pair_t         exp_q[$];
   logic [DW-1:0] m_alpha [NS];
   logic          m_label [NS];
   logic [DW-1:0] m_ab;
   int            m_conv, m_pass, m_to;
   logic [DW-1:0] first_a1;
   vec_t          vecs [3];
   int            n_err = 0;
   int            n_chk = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] resp_a(input int mode, input logic [DW-1:0] a);
      return (mode == M_ECHO) ? a : a + 16'd1;
   endfunction

   function automatic logic [DW-1:0] resp_b(input logic [DW-1:0] a1, input logic [DW-1:0] a2);
      return a1 ^ (a2 << 1);
   endfunction

   task automatic load(input int idx, input logic [DW-1:0] val, input logic lab);
      bus.load_en    = 1'b1;
      bus.load_idx   = IW'(idx);
      bus.load_alpha = val;
      bus.load_label = lab;
      tick();
      bus.load_en    = 1'b0;
      m_alpha[idx]   = val;
      m_label[idx]   = lab;
   endtask

   // Reference model of one run: pushes the expected pair sequence.
   task automatic build_expected(input int mode);
      pair_t p;
      int j, chg;
      logic [DW-1:0] na1, na2;
      m_conv = 0; m_pass = 0; m_to = 0;
      if (mode == M_SILENT) begin
         p.i1 = 0; p.i2 = 1; p.a1 = m_alpha[0]; p.a2 = m_alpha[1];
         p.l1 = m_label[0]; p.l2 = m_label[1];
         exp_q.push_back(p);
         m_to = 1;
         return;
      end
      for (int ps = 0; ps < MAXP; ps++) begin
         chg = 0;
         for (int i = 0; i < NS; i++) begin
            j = (i + 1) % NS;
            p.i1 = IW'(i); p.i2 = IW'(j);
            p.a1 = m_alpha[i]; p.a2 = m_alpha[j];
            p.l1 = m_label[i]; p.l2 = m_label[j];
            exp_q.push_back(p);
            na1 = resp_a(mode, m_alpha[i]);
            na2 = resp_a(mode, m_alpha[j]);
            m_ab = resp_b(m_alpha[i], m_alpha[j]);
            if (na1 != m_alpha[i] || na2 != m_alpha[j]) chg++;
            m_alpha[i] = na1;
            m_alpha[j] = na2;
         end
         m_pass++;
         if (chg == 0) begin
            m_conv = 1;
            break;
         end
      end
   endtask

   // Acts as the update unit until finish (or until the reset injection point).
   task automatic run_until_finish(input int mode, input bit pulse_busy,
                                   input int abort_at, output bit aborted);
      pair_t p;
      bit    pend, abort_pend, done;
      int    n_starts, last_start, finish_cyc, rmode;
      pend = 0; abort_pend = 0; done = 0; aborted = 0;
      n_starts = 0; last_start = -1; finish_cyc = -1;
      rmode = (mode == M_ECHO) ? M_ECHO : M_INC;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         tick();
         bus.start   = 1'b0;
         bus.load_en = 1'b0;
         if (abort_pend) begin
            rst_           = 1'b0;
            bus.cal_finish = 1'b0;
            aborted        = 1;
            done           = 1;
         end else begin
            bus.cal_finish = (mode == M_HOLD);
            if (pend) begin
               bus.cal_finish = 1'b1;
               pend = 0;
            end
            if (pulse_busy && (cyc == 3 || cyc == 17)) begin
               bus.start      = 1'b1;
               bus.load_en    = 1'b1;
               bus.load_idx   = 2'd2;
               bus.load_alpha = 16'hAAAA;
               bus.load_label = 1'b1;
            end
            if (bus.cal_start) begin
               n_starts++;
               if (n_starts == 1) first_a1 = bus.a1;
               if (last_start >= 0) chk("pair_spacing", 64'(cyc - last_start), 64'd5);
               last_start = cyc;
               chk("pair_available", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  p = exp_q.pop_front();
                  $display("pair %0d: idx=(%0d,%0d) a1=0x%0h a2=0x%0h lab=(%0d,%0d)",
                           n_starts, bus.idx1, bus.idx2, bus.a1, bus.a2, bus.label1, bus.label2);
                  chk("idx1", 64'(bus.idx1), 64'(p.i1));
                  chk("idx2", 64'(bus.idx2), 64'(p.i2));
                  chk("a1", 64'(bus.a1), 64'(p.a1));
                  chk("a2", 64'(bus.a2), 64'(p.a2));
                  chk("label1", 64'(bus.label1), 64'(p.l1));
                  chk("label2", 64'(bus.label2), 64'(p.l2));
                  bus.new_a1 = resp_a(rmode, p.a1);
                  bus.new_a2 = resp_a(rmode, p.a2);
                  bus.new_b  = resp_b(p.a1, p.a2);
               end
               if (mode == M_ECHO || mode == M_INC) pend = 1;
               if (n_starts == abort_at) abort_pend = 1;
            end
            if (bus.finish) begin
               done = 1;
               finish_cyc = cyc;
            end
         end
      end
      if (!aborted) begin
         chk("finish_seen", 64'(finish_cyc >= 0), 64'd1);
         if (mode == M_SILENT && finish_cyc >= 0)
            chk("timeout_latency", 64'(finish_cyc - last_start), 64'(CTO));
      end
      bus.cal_finish = 1'b0;
   endtask

   task automatic post_checks();
      chk("converged", 64'(bus.converged), 64'(m_conv));
      chk("timeout", 64'(bus.timeout), 64'(m_to));
      chk("pass_cnt", 64'(bus.pass_cnt), 64'(m_pass));
      chk("a_b", 64'(bus.a_b), 64'(m_ab));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick();
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("finish_pulse", 64'(bus.finish), 64'd0);
      for (int i = 0; i < NS; i++) begin
         bus.rd_idx = IW'(i);
         tick();
         chk("rd_alpha", 64'(bus.rd_alpha), 64'(m_alpha[i]));
      end
   endtask

   initial begin
      bit ab;
      bus.load_en = 0; bus.load_idx = 0; bus.load_alpha = 0; bus.load_label = 0;
      bus.start = 0; bus.cal_finish = 0; bus.new_a1 = 0; bus.new_a2 = 0;
      bus.new_b = 0; bus.rd_idx = 0;
      for (int i = 0; i < NS; i++) begin
         m_alpha[i] = '0;
         m_label[i] = 1'b0;
      end
      m_ab = '0;

      // Reset state
      rst_ = 1'b0;
      tick();
      tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_finish", 64'(bus.finish), 64'd0);
      chk("rst_cal_start", 64'(bus.cal_start), 64'd0);
      chk("rst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
      chk("rst_a_b", 64'(bus.a_b), 64'd0);
      chk("rst_a1", 64'(bus.a1), 64'd0);
      chk("rst_rd_alpha", 64'(bus.rd_alpha), 64'd0);
      rst_ = 1'b1;
      tick();

      // Whole-run vectors: echo converges, increment hits pass limit, silent times out
      vecs[0] = '{M_ECHO,   16'd1, 16'd2, 16'd3, 16'd4, 4'b0101, 1, 1, 0, 16'd1};
      vecs[1] = '{M_INC,    16'd1, 16'd2, 16'd3, 16'd4, 4'b1100, 0, 3, 0, 16'd7};
      vecs[2] = '{M_SILENT, 16'd1, 16'd2, 16'd3, 16'd4, 4'b0011, 0, 0, 1, 16'd1};
      for (int v = 0; v < 3; v++) begin
         load(0, vecs[v].a0, vecs[v].lab[0]);
         load(1, vecs[v].a1, vecs[v].lab[1]);
         load(2, vecs[v].a2, vecs[v].lab[2]);
         load(3, vecs[v].a3, vecs[v].lab[3]);
         build_expected(vecs[v].mode);
         bus.start = 1'b1;
         run_until_finish(vecs[v].mode, 1'b0, 0, ab);
         $display("run %0d: converged=%0d timeout=%0d pass_cnt=%0d",
                  v, bus.converged, bus.timeout, bus.pass_cnt);
         chk("tbl_converged", 64'(bus.converged), 64'(vecs[v].conv));
         chk("tbl_pass_cnt", 64'(bus.pass_cnt), 64'(vecs[v].pass));
         chk("tbl_timeout", 64'(bus.timeout), 64'(vecs[v].to));
         post_checks();
         bus.rd_idx = 0;
         tick();
         chk("tbl_alpha0", 64'(bus.rd_alpha), 64'(vecs[v].alpha0));
      end

      // cal_finish held high throughout, start/load_en pulsed while busy
      for (int i = 0; i < NS; i++) load(i, 16'(i + 1), 1'(i));
      build_expected(M_INC);
      bus.start = 1'b1;
      run_until_finish(M_HOLD, 1'b1, 0, ab);
      $display("hold run: converged=%0d pass_cnt=%0d", bus.converged, bus.pass_cnt);
      post_checks();

      // load_en and start in the same cycle
      bus.load_en = 1'b1; bus.load_idx = 0; bus.load_alpha = 16'h55; bus.load_label = 1'b1;
      m_alpha[0] = 16'h55; m_label[0] = 1'b1;
      bus.start = 1'b1;
      build_expected(M_ECHO);
      run_until_finish(M_ECHO, 1'b0, 0, ab);
      chk("load_start_a1", 64'(first_a1), 64'h55);
      post_checks();

      // Reset during WAIT of the second pass
      build_expected(M_INC);
      bus.start = 1'b1;
      run_until_finish(M_INC, 1'b0, NS + 1, ab);
      chk("abort_reached", 64'(ab), 64'd1);
      tick();
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_finish", 64'(bus.finish), 64'd0);
      chk("abort_pass_cnt", 64'(bus.pass_cnt), 64'd0);
      chk("abort_a_b", 64'(bus.a_b), 64'd0);
      chk("abort_rd_alpha", 64'(bus.rd_alpha), 64'd0);
      rst_ = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NS; i++) begin
         bus.rd_idx = IW'(i);
         tick();
         chk("abort_mem", 64'(bus.rd_alpha), 64'd0);
         chk("abort_no_finish", 64'(bus.finish), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
